// File: rtl/data_router_pkg.sv
// Shared types and helpers for the data router sequencer.
// Contents: bus widths, rpsel encodings (RR/BR/RP/NE), FSM state enum, ncol clamp.
// Optional feature macro used by the users of this package: DATA_ROUTER_CTRL_PERF_EN.
package data_router_pkg;

  localparam int unsigned COLW  = 28;
  localparam int unsigned NBLKW = 8;
  localparam int unsigned ROWW  = 2;
  localparam int unsigned BANKW = 2;
  localparam int unsigned PERFW = 32;

  localparam logic [1:0] RR = 2'b00;
  localparam logic [1:0] BR = 2'b01;
  localparam logic [1:0] RP = 2'b10;
  localparam logic [1:0] NE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SWEEP,
    ST_WAIT_BLK,
    ST_REFILL,
    ST_DONE
  } drc_state_e;

  // A zero or oversized column count means "the whole buffer width".
  function automatic logic [COLW-1:0] clamp_ncol(input logic [COLW-1:0] ncol,
                                                 input logic [COLW-1:0] bufw);
    if ((ncol == '0) || (ncol > bufw)) return bufw;
    return ncol;
  endfunction

endpackage

// File: rtl/data_router_ctrl_if.sv
// Handshake/command bus between the layer controller, the sequencer and the router.
// master: sequencer side (drives cmd_vld/bank/row/col/rpsel/busy/done[/perf_stall]).
// slave : controller/router side (drives start/cfg_ncol/cfg_nblk/ready/blkend).
// perf_stall exists only when DATA_ROUTER_CTRL_PERF_EN is defined.
interface data_router_ctrl_if;
  import data_router_pkg::*;

  logic                  start;
  logic [COLW-1:0]       cfg_ncol;
  logic [NBLKW-1:0]      cfg_nblk;
  logic                  ready;
  logic                  blkend;
  logic                  cmd_vld;
  logic [BANKW-1:0]      bank;
  logic [ROWW-1:0]       row;
  logic [COLW-1:0]       col;
  logic [1:0]            rpsel;
  logic                  busy;
  logic                  done;
`ifdef DATA_ROUTER_CTRL_PERF_EN
  logic [PERFW-1:0]      perf_stall;
`endif

  modport master (
    input  start, cfg_ncol, cfg_nblk, ready, blkend,
`ifdef DATA_ROUTER_CTRL_PERF_EN
    output perf_stall,
`endif
    output cmd_vld, bank, row, col, rpsel, busy, done
  );

  modport slave (
    output start, cfg_ncol, cfg_nblk, ready, blkend,
`ifdef DATA_ROUTER_CTRL_PERF_EN
    input  perf_stall,
`endif
    input  cmd_vld, bank, row, col, rpsel, busy, done
  );

endinterface

// File: rtl/drc_sweep_cnt.sv
// Nested row/col command counter: col steps by step_i until it reaches col_lim_i,
// then wraps to 0 and row advances; after the last row both wrap to 0.
// Ports: clk, rst (async high), clr_i (sync clear), adv_i (advance one command),
//        step_i, row_lim_i, col_lim_i (limits for the current phase),
//        row_o/col_o (registered position), last_c_o (current position is the final one).
module drc_sweep_cnt #(
  parameter int unsigned ROWW = 2,
  parameter int unsigned CW   = 28
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            adv_i,
  input  logic [CW-1:0]   step_i,
  input  logic [ROWW:0]   row_lim_i,
  input  logic [CW-1:0]   col_lim_i,
  output logic [ROWW-1:0] row_o,
  output logic [CW-1:0]   col_o,
  output logic            last_c_o
);

  logic [ROWW-1:0] row_q;
  logic [CW-1:0]   col_q;
  logic [CW:0]     col_sum;
  logic            col_end;
  logic            row_end;

  // One extra bit so the step past the limit cannot wrap around.
  assign col_sum  = {1'b0, col_q} + {1'b0, step_i};
  assign col_end  = (col_sum >= {1'b0, col_lim_i});
  assign row_end  = ({1'b0, row_q} == (row_lim_i - (ROWW+1)'(1)));
  assign last_c_o = col_end & row_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clr_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (adv_i) begin
      if (col_end) begin
        col_q <= '0;
        row_q <= row_end ? '0 : row_q + ROWW'(1);
      end else begin
        col_q <= col_sum[CW-1:0];
      end
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;

endmodule

// File: rtl/data_router_ctrl.sv
// Sequencer for the data router buffer: LOAD (RR), then per block SWEEP (RP),
// WAIT_BLK for the router's block-end strobe, REFILL (BR) of the next bank.
// Ports: clk, rst (async high), bus (data_router_ctrl_if.master).
// Optional: DATA_ROUTER_CTRL_PERF_EN adds perf_stall (cmd_vld && !ready cycles).
module data_router_ctrl
  import data_router_pkg::*;
#(
  parameter int unsigned POY    = 3,
  parameter int unsigned BUFW   = 32,
  parameter int unsigned BUFH   = 3,
  parameter int unsigned KSIZE  = 3,
  parameter int unsigned STRIDE = 1
) (
  input  logic               clk,
  input  logic               rst,
  data_router_ctrl_if.master bus
);

  drc_state_e        state_q;
  logic              cmd_vld_q;
  logic              busy_q;
  logic              done_q;
  logic              pend_q;
  logic [1:0]        rpsel_q;
  logic [BANKW-1:0]  bank_q;
  logic [BANKW-1:0]  bank_ptr_q;
  logic [NBLKW-1:0]  blk_cnt_q;
  logic [NBLKW-1:0]  nblk_q;
  logic [NBLKW-1:0]  blk_nxt;
  logic [COLW-1:0]   ncol_q;

  logic              adv;
  logic              start_acc;
  logic              cnt_last;
  logic [ROWW:0]     row_lim;
  logic [COLW-1:0]   col_lim;
  logic [COLW-1:0]   col_step;
  logic [ROWW-1:0]   cnt_row;
  logic [COLW-1:0]   cnt_col;

  assign adv       = cmd_vld_q & bus.ready;
  assign start_acc = (state_q == ST_IDLE) & bus.start;
  assign blk_nxt   = blk_cnt_q + NBLKW'(1);

  // LOAD/REFILL walk rows only (one column); SWEEP walks the kernel rows x strided columns.
  always_comb begin
    row_lim  = (ROWW+1)'(BUFH);
    col_lim  = COLW'(1);
    col_step = COLW'(1);
    if (state_q == ST_SWEEP) begin
      row_lim  = (ROWW+1)'(KSIZE);
      col_lim  = ncol_q;
      col_step = COLW'(STRIDE);
    end
  end

  drc_sweep_cnt #(.ROWW(ROWW), .CW(COLW)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (start_acc),
    .adv_i     (adv),
    .step_i    (col_step),
    .row_lim_i (row_lim),
    .col_lim_i (col_lim),
    .row_o     (cnt_row),
    .col_o     (cnt_col),
    .last_c_o  (cnt_last)
  );

  // Control FSM; all command fields change only on an accepted command or a phase change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pend_q     <= 1'b0;
      rpsel_q    <= RR;
      bank_q     <= '0;
      bank_ptr_q <= '0;
      blk_cnt_q  <= '0;
      nblk_q     <= NBLKW'(1);
      ncol_q     <= COLW'(BUFW);
    end else begin
      // Early block-end strobes are remembered (merged) until WAIT_BLK consumes them.
      if (bus.blkend && (state_q != ST_IDLE) && (state_q != ST_WAIT_BLK)) pend_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          pend_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.start) begin
            ncol_q     <= clamp_ncol(bus.cfg_ncol, COLW'(BUFW));
            nblk_q     <= (bus.cfg_nblk == '0) ? NBLKW'(1) : bus.cfg_nblk;
            bank_ptr_q <= '0;
            blk_cnt_q  <= '0;
            cmd_vld_q  <= 1'b1;
            rpsel_q    <= RR;
            busy_q     <= 1'b1;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (adv && cnt_last) begin
            rpsel_q <= RP;
            state_q <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          if (adv && cnt_last) begin
            cmd_vld_q <= 1'b0;
            rpsel_q   <= RR;
            blk_cnt_q <= blk_nxt;
            if (blk_nxt == nblk_q) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_WAIT_BLK;
            end
          end
        end
        ST_WAIT_BLK: begin
          if (bus.blkend || pend_q) begin
            pend_q    <= 1'b0;
            cmd_vld_q <= 1'b1;
            rpsel_q   <= BR;
            bank_q    <= bank_ptr_q;
            state_q   <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (adv && cnt_last) begin
            rpsel_q    <= RP;
            bank_q     <= '0;
            bank_ptr_q <= (bank_ptr_q == BANKW'(POY - 1)) ? '0 : bank_ptr_q + BANKW'(1);
            state_q    <= ST_SWEEP;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_vld = cmd_vld_q;
  assign bus.bank    = bank_q;
  assign bus.row     = cnt_row;
  assign bus.col     = cnt_col;
  assign bus.rpsel   = rpsel_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

`ifdef DATA_ROUTER_CTRL_PERF_EN
  logic [PERFW-1:0] perf_q;

  // Stall cycles of the current job; saturating, cleared by an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else if (start_acc) begin
      perf_q <= '0;
    end else if (cmd_vld_q && !bus.ready && (perf_q != '1)) begin
      perf_q <= perf_q + PERFW'(1);
    end
  end

  assign bus.perf_stall = perf_q;
`endif

endmodule

// File: tb/tb_data_router_ctrl.sv
// Self-checking bench for data_router_ctrl (two instances: STRIDE=1 and STRIDE=2).
// Expected command streams come from a job-level model: a queue of the commands a
// job must issue, in order, plus the expected gap/done timing around them.
// Honours DATA_ROUTER_CTRL_PERF_EN for the perf_stall checks.
module tb_data_router_ctrl;

  localparam logic [1:0] T_RR = 2'b00;
  localparam logic [1:0] T_BR = 2'b01;
  localparam logic [1:0] T_RP = 2'b10;

  typedef struct packed {
    logic        eob;
    logic [1:0]  rpsel;
    logic [1:0]  bank;
    logic [1:0]  row;
    logic [27:0] col;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start1 = 1'b0;
  logic        start2 = 1'b0;
  logic        rdy = 1'b0;
  logic        blk = 1'b0;
  logic [27:0] ncol = '0;
  logic [7:0]  nblk = '0;

  int total = 0;
  int bad   = 0;
  cmd_t exp_q[$];

  always #5 clk = ~clk;

  data_router_ctrl_if bus1();
  data_router_ctrl_if bus2();

  assign bus1.start    = start1;
  assign bus1.cfg_ncol = ncol;
  assign bus1.cfg_nblk = nblk;
  assign bus1.ready    = rdy;
  assign bus1.blkend   = blk;
  assign bus2.start    = start2;
  assign bus2.cfg_ncol = ncol;
  assign bus2.cfg_nblk = nblk;
  assign bus2.ready    = rdy;
  assign bus2.blkend   = blk;

  data_router_ctrl #(.STRIDE(1)) u_dut  (.clk(clk), .rst(rst), .bus(bus1.master));
  data_router_ctrl #(.STRIDE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t cur_cmd(input int sel);
    cmd_t c;
    c.eob = 1'b0;
    if (sel == 1) begin
      c.rpsel = bus1.rpsel; c.bank = bus1.bank; c.row = bus1.row; c.col = bus1.col;
    end else begin
      c.rpsel = bus2.rpsel; c.bank = bus2.bank; c.row = bus2.row; c.col = bus2.col;
    end
    return c;
  endfunction

  function automatic logic cur_vld(input int sel);
    return (sel == 1) ? bus1.cmd_vld : bus2.cmd_vld;
  endfunction
  function automatic logic cur_busy(input int sel);
    return (sel == 1) ? bus1.busy : bus2.busy;
  endfunction
  function automatic logic cur_done(input int sel);
    return (sel == 1) ? bus1.done : bus2.done;
  endfunction
`ifdef DATA_ROUTER_CTRL_PERF_EN
  function automatic logic [31:0] cur_perf(input int sel);
    return (sel == 1) ? bus1.perf_stall : bus2.perf_stall;
  endfunction
`endif

  // Only the fields that matter for each command type are compared.
  function automatic cmd_t mask(input cmd_t c);
    cmd_t m = c;
    m.eob = 1'b0;
    if (m.rpsel != T_RP) m.col = '0;
    if (m.rpsel != T_BR) m.bank = '0;
    return m;
  endfunction

  // Whole-job command list: LOAD rows, then per block (REFILL of the previous bank) + sweep.
  task automatic build(input int ncol_i, input int nblk_i, input int stride);
    int nc = ((ncol_i == 0) || (ncol_i > 32)) ? 32 : ncol_i;
    int nb = (nblk_i == 0) ? 1 : nblk_i;
    exp_q.delete();
    for (int r = 0; r < 3; r++) exp_q.push_back(cmd_t'{1'b0, T_RR, 2'd0, 2'(r), 28'd0});
    for (int b = 0; b < nb; b++) begin
      if (b > 0)
        for (int r = 0; r < 3; r++)
          exp_q.push_back(cmd_t'{1'b0, T_BR, 2'((b - 1) % 3), 2'(r), 28'd0});
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < nc; c += stride)
          exp_q.push_back(cmd_t'{1'b0, T_RP, 2'd0, 2'(r), 28'(c)});
      exp_q[exp_q.size() - 1].eob = 1'b1;
    end
  endtask

  // rmode: 0 ready high, 1 ready toggling, 2 random. dly: cycles after WAIT entry
  // before blkend. early: pulse blkend mid-sweep so WAIT leaves on the pending flag.
  task automatic run_job(input int sel, input int ncol_i, input int nblk_i, input int stride,
                         input int rmode, input int dly, input bit early,
                         output int lat, output int stalls);
    logic vld_exp, done_exp, r, pend, pulsed, fin;
    int   gap, cyc;
    cmd_t front;
    build(ncol_i, nblk_i, stride);
    ncol = 28'(ncol_i);
    nblk = 8'(nblk_i);
    rdy = 1'b1;
    blk = 1'b0;
    lat = 0;
    stalls = 0;
    @(negedge clk);
    if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    vld_exp = 1'b1; done_exp = 1'b0; pend = 1'b0; pulsed = 1'b0; fin = 1'b0;
    gap = 0; cyc = 0;
    while (!fin) begin
      if (cyc > 3000) begin
        total++; bad++;
        $error("FAIL timeout: job not finished after %0d cycles", cyc);
        break;
      end
      blk = 1'b0;
      chk("cmd_vld", 64'(cur_vld(sel)), 64'(vld_exp));
      chk("done", 64'(cur_done(sel)), 64'(done_exp));
      chk("busy", 64'(cur_busy(sel)), 64'd1);
      if (done_exp) begin
        lat = cyc + 1;
        fin = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        rdy = 1'b1;
      end else if (vld_exp) begin
        front = exp_q[0];
        chk("cmd", 64'(mask(cur_cmd(sel))), 64'(mask(front)));
        r = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((cyc % 2) == 0) : 1'($urandom % 2);
        rdy = r;
        // start and cfg changes while busy must be ignored
        if (sel == 1) start1 = 1'($urandom % 2); else start2 = 1'($urandom % 2);
        ncol = 28'($urandom);
        if (early && !pulsed && front.rpsel == T_RP && front.row == 2'd1) begin
          blk = 1'b1; pulsed = 1'b1; pend = 1'b1;
        end
        if (!r) stalls++;
        else begin
          void'(exp_q.pop_front());
          if (front.eob) begin
            vld_exp = 1'b0;
            pulsed = 1'b0;
            gap = 0;
            if (exp_q.size() == 0) begin
              done_exp = 1'b1;
              pend = 1'b0;
            end
          end
        end
      end else begin
        if (pend) begin
          pend = 1'b0;
          vld_exp = 1'b1;
        end else if (gap == dly) begin
          blk = 1'b1;
          vld_exp = 1'b1;
        end else begin
          gap++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start1 = 1'b0;
    start2 = 1'b0;
    blk = 1'b0;
    chk("done_fall", 64'(cur_done(sel)), 64'd0);
    chk("busy_fall", 64'(cur_busy(sel)), 64'd0);
    chk("idle_vld", 64'(cur_vld(sel)), 64'd0);
    chk("idle_fields", 64'(cur_cmd(sel)), 64'(cmd_t'{1'b0, T_RR, 2'd0, 2'd0, 28'd0}));
    chk("cmds_left", 64'(exp_q.size()), 64'd0);
`ifdef DATA_ROUTER_CTRL_PERF_EN
    chk("perf_stall", 64'(cur_perf(sel)), 64'(stalls));
`endif
  endtask

  initial begin
    int lat, st;
    cmd_t idle_c;
    idle_c = cmd_t'{1'b0, T_RR, 2'd0, 2'd0, 28'd0};

    // reset values
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_vld", 64'(bus1.cmd_vld), 64'd0);
    chk("rst_busy", 64'(bus1.busy), 64'd0);
    chk("rst_done", 64'(bus1.done), 64'd0);
    chk("rst_fields", 64'(cur_cmd(1)), 64'(idle_c));
`ifdef DATA_ROUTER_CTRL_PERF_EN
    chk("rst_perf", 64'(bus1.perf_stall), 64'd0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single block, 16 columns: 3 RR + 48 RP, done 52 cycles after start
    run_job(1, 16, 1, 1, 0, 0, 1'b0, lat, st);
    chk("done_latency", 64'(lat), 64'd52);

    // STRIDE=2 instance: even columns only
    run_job(2, 16, 1, 2, 0, 0, 1'b0, lat, st);
    chk("stride2_latency", 64'(lat), 64'd28);

    // four blocks, blkend 5 cycles after each WAIT entry; REFILL banks 0,1,2
    run_job(1, 6, 4, 1, 0, 5, 1'b0, lat, st);

    // ready toggling through the job; blkend in the WAIT entry cycle
    run_job(1, 8, 2, 1, 1, 0, 1'b0, lat, st);

    // early blkend held in the pending flag; ncol=0 sweeps 32 columns
    run_job(1, 0, 3, 1, 0, 3, 1'b1, lat, st);

    // randomized jobs
    for (int j = 0; j < 4; j++)
      run_job(1, int'($urandom_range(0, 40)), int'($urandom_range(0, 5)), 1, 2,
              int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), lat, st);
    run_job(2, int'($urandom_range(1, 40)), int'($urandom_range(1, 4)), 2, 2,
            int'($urandom_range(0, 3)), 1'b0, lat, st);

    // reset mid-sweep aborts at once with no done pulse
    ncol = 28'd16;
    nblk = 8'd2;
    rdy  = 1'b1;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_rst_sweep", 64'(bus1.rpsel), 64'(T_RP));
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", 64'(bus1.cmd_vld), 64'd0);
    chk("mid_rst_busy", 64'(bus1.busy), 64'd0);
    chk("mid_rst_done", 64'(bus1.done), 64'd0);
    chk("mid_rst_fields", 64'(cur_cmd(1)), 64'(idle_c));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_done", 64'(bus1.done), 64'd0);
      chk("post_rst_vld", 64'(bus1.cmd_vld), 64'd0);
    end

    // clean job after the abort
    run_job(1, 10, 2, 1, 0, 1, 1'b0, lat, st);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
